// File: rtl/pend_encode8_3_pkg.sv
// Shared sizes and index/one-hot helpers for the pending-request encoder.
// The same conversion backs the 3->8 decoders elsewhere in the pipeline.
package pend_encode8_3_pkg;

   localparam int REQ_N = 8;
   localparam int IDX_W = 3;

   typedef logic [REQ_N-1:0] req_t;
   typedef logic [IDX_W-1:0] idx_t;

   function automatic req_t idx2oh(input idx_t idx);
      return req_t'(1) << idx;
   endfunction

   function automatic req_t rotr(input req_t v, input idx_t sh);
      logic [2*REQ_N-1:0] dbl;
      dbl = {v, v} >> sh;
      return dbl[REQ_N-1:0];
   endfunction

endpackage

// File: rtl/pend_encode8_3_if.sv
// Request/handshake bundle between request sources, encoder and consumer.
// The slave side is the encoder; the master side drives requests and ready.
interface pend_encode8_3_if;
   import pend_encode8_3_pkg::*;

   req_t req_in;
   logic flush;
   logic out_ready;
   logic out_valid;
   idx_t out_idx;
   req_t out_onehot;
   req_t pend;

   modport master (
      output req_in, flush, out_ready,
      input  out_valid, out_idx, out_onehot, pend
   );

   modport slave (
      input  req_in, flush, out_ready,
      output out_valid, out_idx, out_onehot, pend
   );

endinterface

// File: rtl/pend_encode8_3_prienc8_3.sv
// Combinational lowest-set-bit encoder with a found flag.
module prienc8_3
   import pend_encode8_3_pkg::*;
(
   input  req_t vec,
   output idx_t idx,
   output logic found
);

   always_comb begin
      idx   = '0;
      found = |vec;
      for (int i = REQ_N - 1; i >= 0; i--) begin
         if (vec[i]) idx = idx_t'(i);
      end
   end

endmodule

// File: rtl/pend_encode8_3.sv
// Sticky pending bits presented one at a time as index + one-hot, with
// round-robin (RR=1) or fixed lowest-index (RR=0) selection.
module pend_encode8_3
   import pend_encode8_3_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   pend_encode8_3_if.slave   bus
);

   req_t pending;
   idx_t ptr;
   idx_t base;
   req_t rotated;
   idx_t enc_idx;
   logic found;
   idx_t sel_idx;
   req_t clr_mask;
   logic accept;

   // Rotate so the scan starts at base, then undo the rotation on the index.
   assign base    = RR ? ptr : '0;
   assign rotated = rotr(pending, base);

   prienc8_3 u_enc (
      .vec   (rotated),
      .idx   (enc_idx),
      .found (found)
   );

   assign sel_idx  = found ? idx_t'(enc_idx + base) : '0;
   assign accept   = found & bus.out_ready;
   assign clr_mask = accept ? idx2oh(sel_idx) : '0;

   assign bus.out_valid  = found;
   assign bus.out_idx    = sel_idx;
   assign bus.out_onehot = found ? idx2oh(sel_idx) : '0;
   assign bus.pend       = pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         ptr     <= '0;
      end else if (bus.flush) begin
         pending <= '0;
      end else begin
         // A new request on the bit being served keeps it pending.
         pending <= (pending & ~clr_mask) | bus.req_in;
         if (RR && accept) ptr <= idx_t'(sel_idx + 1'b1);
      end
   end

endmodule

// File: tb/tb_pend_encode8_3.sv
// Bench for pend_encode8_3: RR and fixed instances against a queue-free model.
module tb_pend_encode8_3;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pend_encode8_3_if bus_rr();
   pend_encode8_3_if bus_fx();

   pend_encode8_3 #(.RR(1'b1)) u_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   pend_encode8_3 #(.RR(1'b0)) u_fx (
      .clk (clk),
      .rst (rst),
      .bus (bus_fx)
   );

   logic [7:0] mp [2];
   int         mptr [2];
   bit         known = 1'b0;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Reference: walk the 8 positions starting at the pointer, first hit wins.
   function automatic void msel(input logic [7:0] p, input int b,
                                output logic v, output logic [2:0] idx);
      v   = 1'b0;
      idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         int i;
         i = (b + k) % 8;
         if (!v && p[i]) begin
            v   = 1'b1;
            idx = 3'(i);
         end
      end
   endfunction

   function automatic void mupd(input int k, input logic [7:0] r,
                                input logic f, input logic rd, input logic rs);
      logic v;
      logic [2:0] idx;
      int b;
      b = (k == 0) ? mptr[k] : 0;
      msel(mp[k], b, v, idx);
      if (rs) begin
         mp[k]   = 8'h00;
         mptr[k] = 0;
      end else if (f) begin
         mp[k] = 8'h00;
      end else begin
         if (v && rd) begin
            mp[k][idx] = 1'b0;
            if (k == 0) mptr[k] = (int'(idx) + 1) % 8;
         end
         mp[k] = mp[k] | r;
      end
   endfunction

   task automatic check_dut(input int k);
      logic v;
      logic [2:0] idx;
      logic [7:0] oh;
      int b;
      b = (k == 0) ? mptr[k] : 0;
      msel(mp[k], b, v, idx);
      oh = v ? (8'h01 << idx) : 8'h00;
      if (k == 0) begin
         check("rr_valid", {7'd0, bus_rr.out_valid}, {7'd0, v});
         check("rr_idx", {5'd0, bus_rr.out_idx}, {5'd0, idx});
         check("rr_onehot", bus_rr.out_onehot, oh);
         check("rr_pend", bus_rr.pend, mp[k]);
      end else begin
         check("fx_valid", {7'd0, bus_fx.out_valid}, {7'd0, v});
         check("fx_idx", {5'd0, bus_fx.out_idx}, {5'd0, idx});
         check("fx_onehot", bus_fx.out_onehot, oh);
         check("fx_pend", bus_fx.pend, mp[k]);
      end
   endtask

   task automatic cyc(input logic [7:0] r, input logic f,
                      input logic rd, input logic rs);
      @(negedge clk);
      rst              = rs;
      bus_rr.req_in    = r;
      bus_fx.req_in    = r;
      bus_rr.flush     = f;
      bus_fx.flush     = f;
      bus_rr.out_ready = rd;
      bus_fx.out_ready = rd;
      if (known) begin
         check_dut(0);
         check_dut(1);
      end
      @(posedge clk);
      #1;
      mupd(0, r, f, rd, rs);
      mupd(1, r, f, rd, rs);
      if (rs) known = 1'b1;
   endtask

   initial begin
      logic [2:0] seq [4];
      seq[0] = 3'd0;
      seq[1] = 3'd1;
      seq[2] = 3'd4;
      seq[3] = 3'd7;
      mp[0] = 8'h00;
      mp[1] = 8'h00;
      mptr[0] = 0;
      mptr[1] = 0;

      // Reset with all requests asserted.
      cyc(8'hFF, 1'b0, 1'b0, 1'b1);
      cyc(8'hFF, 1'b0, 1'b0, 1'b1);
      check("rst_pend", bus_rr.pend, 8'h00);
      check("rst_valid", {7'd0, bus_rr.out_valid}, 8'h00);
      check("rst_idx", {5'd0, bus_rr.out_idx}, 8'h00);

      // Single request.
      cyc(8'h20, 1'b0, 1'b0, 1'b0);
      check("single_idx", {5'd0, bus_rr.out_idx}, 8'd5);
      check("single_oh", bus_rr.out_onehot, 8'h20);
      cyc(8'h00, 1'b0, 1'b1, 1'b0);
      check("single_clr", bus_rr.pend, 8'h00);

      // Round-robin order, wrapping after index 7.
      cyc(8'h00, 1'b0, 1'b0, 1'b1);
      cyc(8'h93, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s < 4; s++) begin
         check("rr_seq", {5'd0, bus_rr.out_idx}, {5'd0, seq[s]});
         cyc(8'h00, 1'b0, 1'b1, 1'b0);
      end
      check("rr_empty", {7'd0, bus_rr.out_valid}, 8'h00);
      cyc(8'h81, 1'b0, 1'b0, 1'b0);
      check("rr_wrap", {5'd0, bus_rr.out_idx}, 8'd0);

      // Fixed priority starves index 7.
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h81, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s < 4; s++) begin
         check("fx_starve", {5'd0, bus_fx.out_idx}, 8'd0);
         cyc(8'h01, 1'b0, 1'b1, 1'b0);
      end
      check("fx_pend7", bus_fx.pend, 8'h81);

      // Set wins over clear on the same bit.
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h08, 1'b0, 1'b0, 1'b0);
      cyc(8'h08, 1'b0, 1'b1, 1'b0);
      check("coll_pend", bus_rr.pend, 8'h08);
      check("coll_valid", {7'd0, bus_rr.out_valid}, 8'h01);

      // Flush drops same-cycle requests; reset mid-stream clears all.
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
      cyc(8'h3C, 1'b0, 1'b0, 1'b0);
      cyc(8'h01, 1'b1, 1'b1, 1'b0);
      check("flush_pend", bus_rr.pend, 8'h00);
      check("flush_valid", {7'd0, bus_rr.out_valid}, 8'h00);
      cyc(8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b1, 1'b1);
      check("rst_mid", bus_rr.pend, 8'h00);
      check("rst_mid_fx", bus_fx.pend, 8'h00);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         logic [7:0] r;
         r = 8'($urandom) & 8'($urandom) & 8'($urandom);
         cyc(r, ($urandom_range(0, 15) == 0), 1'($urandom),
             ($urandom_range(0, 63) == 0));
      end
      cyc(8'h00, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
